// File: rtl/taxi_qsfp_port_seq.sv
// QSFP cage bring-up sequencer: tracks presence of each cage, brings up one
// module at a time (reset pulse, then init wait) in round-robin order, and
// reports module interrupts through a valid/ready event channel.
module taxi_qsfp_port_seq #(
    parameter int unsigned PORT_CNT     = 15,
    parameter int unsigned RESET_CYCLES = 1250,
    parameter int unsigned INIT_CYCLES  = 250000,
    localparam int unsigned IDX_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic [PORT_CNT-1:0] port_modprsl,
    input  logic [PORT_CNT-1:0] port_intl,
    input  logic [PORT_CNT-1:0] port_reset_req,
    output logic [PORT_CNT-1:0] port_resetl,
    output logic [PORT_CNT-1:0] port_ready,
    output logic                busy,
    output logic [IDX_W-1:0]    active_port,
    output logic                int_valid,
    output logic [IDX_W-1:0]    int_port,
    input  logic                int_ready
);

    localparam int unsigned MAX_CYC = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] RESET_LAST = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] INIT_LAST  = TMR_W'(INIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PORT_CNT - 1);

    typedef enum logic [1:0] {P_ABSENT, P_PENDING, P_UP} port_state_t;
    typedef enum logic [1:0] {S_IDLE, S_RESET, S_INIT} seq_state_t;

    logic                run;
    port_state_t         ps   [PORT_CNT];
    port_state_t         ps_n [PORT_CNT];
    seq_state_t          st, st_n;
    logic [IDX_W-1:0]    act, act_n, rr, rr_n, gnt, ip_n;
    logic [TMR_W-1:0]    tmr, tmr_n;
    logic [PORT_CNT-1:0] armed, armed_n;
    logic                iv_n, found, ifound, abort, done, accept;
    int unsigned         idx;

    // Reset release synchroniser: state is frozen until the edge after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Next-state logic for port states, sequencer and interrupt channel
    always_comb begin
        st_n    = st;
        act_n   = act;
        rr_n    = rr;
        tmr_n   = tmr;
        done    = 1'b0;
        found   = 1'b0;
        ifound  = 1'b0;
        gnt     = '0;
        idx     = 0;
        iv_n    = int_valid;
        ip_n    = int_port;
        accept  = int_valid && int_ready;
        abort   = (st != S_IDLE) &&
                  (port_modprsl[act] || port_reset_req[act] || !pll_locked);

        // Round-robin search starting at rr; ports being removed are skipped
        for (int unsigned k = 0; k < PORT_CNT; k++) begin
            idx = k + 32'(rr);
            if (idx >= PORT_CNT) idx = idx - PORT_CNT;
            if (!found && ps[idx] == P_PENDING && !port_modprsl[idx]) begin
                found = 1'b1;
                gnt   = IDX_W'(idx);
            end
        end

        case (st)
            S_IDLE: begin
                if (pll_locked && found) begin
                    st_n  = S_RESET;
                    act_n = gnt;
                    tmr_n = '0;
                end
            end
            S_RESET: begin
                if (abort) begin
                    st_n  = S_IDLE;
                    tmr_n = '0;
                end else if (tmr == RESET_LAST) begin
                    st_n  = S_INIT;
                    tmr_n = '0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            S_INIT: begin
                if (abort) begin
                    st_n  = S_IDLE;
                    tmr_n = '0;
                end else if (tmr == INIT_LAST) begin
                    st_n  = S_IDLE;
                    tmr_n = '0;
                    done  = 1'b1;
                    rr_n  = (act == LAST_IDX) ? '0 : act + 1'b1;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            default: st_n = S_IDLE;
        endcase

        for (int unsigned i = 0; i < PORT_CNT; i++) begin
            if (port_modprsl[i])                         ps_n[i] = P_ABSENT;
            else if (ps[i] == P_ABSENT)                  ps_n[i] = P_PENDING;
            else if (port_reset_req[i])                  ps_n[i] = P_PENDING;
            else if (!pll_locked && ps[i] == P_UP)       ps_n[i] = P_PENDING;
            else if (done && act == IDX_W'(i))           ps_n[i] = P_UP;
            else                                         ps_n[i] = ps[i];
            armed_n[i] = port_intl[i] | (armed[i] & ~(accept && int_port == IDX_W'(i)));
        end

        // Held event is dropped on accept or when its port leaves UP;
        // a new event is only offered from an idle channel.
        if (int_valid) begin
            if (accept || ps_n[int_port] != P_UP) iv_n = 1'b0;
        end else begin
            for (int unsigned i = 0; i < PORT_CNT; i++) begin
                if (!ifound && ps_n[i] == P_UP && armed[i] && !port_intl[i]) begin
                    ifound = 1'b1;
                    iv_n   = 1'b1;
                    ip_n   = IDX_W'(i);
                end
            end
        end
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PORT_CNT; i++) ps[i] <= P_ABSENT;
            st          <= S_IDLE;
            act         <= '0;
            rr          <= '0;
            tmr         <= '0;
            armed       <= '0;
            port_resetl <= '0;
            port_ready  <= '0;
            busy        <= 1'b0;
            active_port <= '0;
            int_valid   <= 1'b0;
            int_port    <= '0;
        end else if (run) begin
            for (int unsigned i = 0; i < PORT_CNT; i++) begin
                ps[i]          <= ps_n[i];
                port_resetl[i] <= (ps_n[i] == P_UP) || (st_n == S_INIT && act_n == IDX_W'(i));
                port_ready[i]  <= (ps_n[i] == P_UP);
            end
            st          <= st_n;
            act         <= act_n;
            rr          <= rr_n;
            tmr         <= tmr_n;
            armed       <= armed_n;
            busy        <= (st_n != S_IDLE);
            active_port <= act_n;
            int_valid   <= iv_n;
            int_port    <= ip_n;
        end
    end

endmodule

// File: tb/tb_taxi_qsfp_port_seq.sv
// Self-checking bench for taxi_qsfp_port_seq with a cycle-level reference
// model built from the port/sequencer/interrupt rules (countdown phases).
module tb_taxi_qsfp_port_seq;

    localparam int N  = 4;
    localparam int RC = 4;
    localparam int IC = 8;
    localparam int ABS = 0, PEND = 1, UP = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pll_locked = 1'b1;
    logic [N-1:0] port_modprsl = '1;
    logic [N-1:0] port_intl = '1;
    logic [N-1:0] port_reset_req = '0;
    logic         int_ready = 1'b0;
    logic [N-1:0] port_resetl, port_ready;
    logic         busy, int_valid;
    logic [1:0]   active_port, int_port;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_ps [N];
    int m_phase, m_left, m_act, m_rr, m_ip;
    bit m_armed [N];
    bit m_iv, m_run;

    taxi_qsfp_port_seq #(.PORT_CNT(N), .RESET_CYCLES(RC), .INIT_CYCLES(IC)) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .port_modprsl(port_modprsl), .port_intl(port_intl), .port_reset_req(port_reset_req),
        .port_resetl(port_resetl), .port_ready(port_ready), .busy(busy),
        .active_port(active_port), .int_valid(int_valid), .int_port(int_port),
        .int_ready(int_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {port_resetl, port_ready, busy, active_port, int_valid, int_port};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [N-1:0] r, rd;
        for (int i = 0; i < N; i++) begin
            rd[i] = (m_ps[i] == UP);
            r[i]  = (m_ps[i] == UP) || (m_phase == 2 && m_act == i);
        end
        return {r, rd, m_phase != 0, 2'(m_act), m_iv, 2'(m_ip)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_ps[i] = ABS; m_armed[i] = 0; end
        m_phase = 0; m_left = 0; m_act = 0; m_rr = 0; m_ip = 0; m_iv = 0; m_run = 0;
    endtask

    task automatic model_step();
        int  nps [N];
        bit  narm [N];
        bit  kill, fin, acc;
        int  p;
        if (!rst_n) return;
        if (!m_run) begin m_run = 1; return; end
        kill = m_phase != 0 && (port_modprsl[m_act] || port_reset_req[m_act] || !pll_locked);
        fin  = m_phase == 2 && m_left == 1 && !kill;
        acc  = m_iv && int_ready;
        for (int i = 0; i < N; i++) begin
            if (port_modprsl[i])                  nps[i] = ABS;
            else if (m_ps[i] == ABS)              nps[i] = PEND;
            else if (port_reset_req[i])           nps[i] = PEND;
            else if (!pll_locked && m_ps[i] == UP) nps[i] = PEND;
            else if (fin && m_act == i)           nps[i] = UP;
            else                                  nps[i] = m_ps[i];
            narm[i] = port_intl[i] || (m_armed[i] && !(acc && m_ip == i));
        end
        if (kill) m_phase = 0;
        else if (m_phase == 1) begin
            if (m_left == 1) begin m_phase = 2; m_left = IC; end
            else m_left--;
        end else if (m_phase == 2) begin
            if (fin) begin m_phase = 0; m_rr = (m_act + 1) % N; end
            else m_left--;
        end else if (pll_locked) begin
            for (int k = 0; k < N; k++) begin
                p = (m_rr + k) % N;
                if (m_ps[p] == PEND && !port_modprsl[p]) begin
                    m_phase = 1; m_left = RC; m_act = p; break;
                end
            end
        end
        if (m_iv) begin
            if (acc || nps[m_ip] != UP) m_iv = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (nps[i] == UP && m_armed[i] && !port_intl[i]) begin
                    m_iv = 1; m_ip = i; break;
                end
        end
        for (int i = 0; i < N; i++) begin m_ps[i] = nps[i]; m_armed[i] = narm[i]; end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        pll_locked = 1'b1; port_modprsl = '1; port_intl = '1; port_reset_req = '0; int_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        port_modprsl = 4'b1110; pll_locked = 1'b1;
        repeat (2) step();
        checks++;
        if (dut_vec() !== 14'h0) begin errors++; $display("FAIL reset_values got=%h want=0", dut_vec()); end
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (busy !== (e == 3)) begin errors++; $display("FAIL reset_release edge=%0d busy got=%b want=%b", e, busy, e == 3); end
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_model got=%h want=%h", dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_single_insert();
        do_reset();
        port_modprsl = 4'b1110;
        for (int c = 1; c <= 16; c++) begin
            step();
            checks++;
            if (busy !== (c >= 2 && c < 14)) begin errors++; $display("FAIL single_busy c=%0d got=%b", c, busy); end
            checks++;
            if (port_resetl[0] !== (c >= 6)) begin errors++; $display("FAIL single_resetl c=%0d got=%b want=%b", c, port_resetl[0], c >= 6); end
            checks++;
            if (port_ready[0] !== (c >= 14)) begin errors++; $display("FAIL single_ready c=%0d got=%b want=%b", c, port_ready[0], c >= 14); end
            if (c >= 2 && c < 14) begin
                checks++;
                if (active_port !== 2'd0) begin errors++; $display("FAIL single_active c=%0d got=%0d want=0", c, active_port); end
            end
        end
    endtask

    task automatic test_round_robin();
        int  order[$];
        logic prev_busy;
        do_reset();
        port_modprsl = 4'b0000;
        prev_busy = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (busy && !prev_busy) order.push_back(int'(active_port));
            prev_busy = busy;
            checks++;
            if ($countones(port_resetl & ~port_ready) > 1) begin errors++; $display("FAIL rr_overlap resetl=%b ready=%b", port_resetl, port_ready); end
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rr_model got=%h want=%h", dut_vec(), exp_vec()); end
        end
        checks++;
        if (order.size() != 4) begin errors++; $display("FAIL rr_grants got=%0d want=4", order.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != i) begin errors++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], i); end
        end
        checks++;
        if (port_ready !== 4'hF) begin errors++; $display("FAIL rr_all_ready got=%b want=1111", port_ready); end
    endtask

    task automatic test_removal();
        int n = 0;
        do_reset();
        port_modprsl = 4'b0000;
        while (!(busy && active_port == 2'd1 && port_resetl[1]) && n < 200) begin
            step(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rm_model got=%h want=%h", dut_vec(), exp_vec()); end
        end
        checks++;
        if (!(busy && active_port == 2'd1 && port_resetl[1])) begin errors++; $display("FAIL rm_timeout got=%b want=1", busy); end
        port_modprsl = 4'b0010;
        step();
        checks++;
        if (port_resetl[1] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_abort resetl1=%b busy=%b want=0,0", port_resetl[1], busy); end
        step();
        checks++;
        if (busy !== 1'b1 || active_port !== 2'd2) begin errors++; $display("FAIL rm_next busy=%b active=%0d want=1,2", busy, active_port); end
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rm_model2 got=%h want=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_pll_loss();
        int n = 0;
        do_reset();
        port_modprsl = 4'b1010;
        while (port_ready !== 4'b0101 && n < 100) begin step(); n++; end
        checks++;
        if (port_ready !== 4'b0101) begin errors++; $display("FAIL pll_bringup got=%b want=0101", port_ready); end
        pll_locked = 1'b0;
        step();
        checks++;
        if (port_ready !== 4'b0000) begin errors++; $display("FAIL pll_ready_drop got=%b want=0000", port_ready); end
        repeat (6) begin
            step();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL pll_no_grant busy got=%b want=0", busy); end
        end
        pll_locked = 1'b1;
        n = 0;
        while (port_ready !== 4'b0101 && n < 100) begin
            step(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL pll_model got=%h want=%h", dut_vec(), exp_vec()); end
        end
        checks++;
        if (port_ready !== 4'b0101) begin errors++; $display("FAIL pll_resequence got=%b want=0101", port_ready); end
    endtask

    task automatic test_interrupts();
        int n = 0;
        do_reset();
        port_modprsl = 4'b0101;
        while (port_ready !== 4'b1010 && n < 100) begin step(); n++; end
        checks++;
        if (port_ready !== 4'b1010) begin errors++; $display("FAIL int_bringup got=%b want=1010", port_ready); end
        port_intl = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (int_valid !== 1'b1 || int_port !== 2'd1) begin errors++; $display("FAIL int_hold c=%0d valid=%b port=%0d want=1,1", c, int_valid, int_port); end
        end
        int_ready = 1'b1;
        step();
        checks++;
        if (int_valid !== 1'b0) begin errors++; $display("FAIL int_accept valid got=%b want=0", int_valid); end
        step();
        checks++;
        if (int_valid !== 1'b1 || int_port !== 2'd3) begin errors++; $display("FAIL int_second valid=%b port=%0d want=1,3", int_valid, int_port); end
        step();
        repeat (4) begin
            step();
            checks++;
            if (int_valid !== 1'b0) begin errors++; $display("FAIL int_disarmed valid got=%b want=0", int_valid); end
        end
        port_intl[1] = 1'b1;
        step();
        port_intl[1] = 1'b0;
        step();
        checks++;
        if (int_valid !== 1'b1 || int_port !== 2'd1) begin errors++; $display("FAIL int_rearm valid=%b port=%0d want=1,1", int_valid, int_port); end
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL int_model got=%h want=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        port_modprsl = 4'b1110;
        repeat (4) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre busy got=%b want=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 14'h0) begin errors++; $display("FAIL arst_values got=%h want=0", dut_vec()); end
        do_reset();
    endtask

    task automatic test_random();
        int pll_lo = 0;
        do_reset();
        port_modprsl = 4'(($urandom) & 4'hF);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) port_modprsl[$urandom_range(0, 3)] ^= 1'b1;
            port_reset_req = ($urandom_range(0, 29) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            if (pll_lo == 0 && $urandom_range(0, 149) == 0) pll_lo = $urandom_range(1, 5);
            pll_locked = (pll_lo == 0);
            if (pll_lo > 0) pll_lo--;
            if ($urandom_range(0, 7) == 0) port_intl[$urandom_range(0, 3)] ^= 1'b1;
            int_ready = ($urandom_range(0, 2) == 0);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rand_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec()); end
        end
        port_reset_req = '0;
    endtask

    initial begin
        test_reset();
        test_single_insert();
        test_round_robin();
        test_removal();
        test_pll_loss();
        test_interrupts();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/taxi_qsfp_port_seq.md
TAXI_QSFP_PORT_SEQ -- requirements
Module: taxi_qsfp_port_seq

Interface
REQ-001 Parameter PORT_CNT, default 15, number of QSFP cages managed.
REQ-002 Parameter RESET_CYCLES, default 1250, resetl low-time per bring-up (10 us at 125 MHz).
REQ-003 Parameter INIT_CYCLES, default 250000, post-reset module init wait (2 ms at 125 MHz).
REQ-004 Localparam IDX_W = max(1, $clog2(PORT_CNT)).
REQ-005 Ports SHALL be:
  - clk, input, 1: single clock.
  - rst_n, input, 1: asynchronous active-low reset.
  - pll_locked, input, 1: reference PLLs locked, synchronous to clk.
  - port_modprsl, input, PORT_CNT: module present, active low, pre-synchronised.
  - port_intl, input, PORT_CNT: module interrupt, active low, pre-synchronised.
  - port_reset_req, input, PORT_CNT: single-cycle pulse requesting a port re-bring-up.
  - port_resetl, output, PORT_CNT: module reset, active low.
  - port_ready, output, PORT_CNT: module out of reset and initialised.
  - busy, output, 1: sequencer in RESET or INIT.
  - active_port, output, IDX_W: port currently sequenced.
  - int_valid, output, 1: interrupt event handshake, valid.
  - int_port, output, IDX_W: interrupt event port index.
  - int_ready, input, 1: interrupt event accept.

Function
REQ-006 Each port SHALL hold one state: ABSENT, PENDING or UP.
REQ-007 ABSENT -> PENDING the cycle after port_modprsl[i]=0 is sampled; UP or PENDING -> ABSENT the cycle after port_modprsl[i]=1 is sampled.
REQ-008 port_reset_req[i] on a present port SHALL force PENDING; it SHALL be ignored on an ABSENT port.
REQ-009 One shared sequencer FSM SHALL have states IDLE, RESET and INIT, so that at most one port is in bring-up at any time (inrush limiting).
REQ-010 IDLE with pll_locked=1 and any PENDING port: grant the first PENDING index at or above rr_ptr, wrapping. Next cycle: RESET, active_port = grant, busy=1.
REQ-011 RESET SHALL last exactly RESET_CYCLES cycles, then go to INIT.
REQ-012 INIT SHALL last exactly INIT_CYCLES cycles. Then:
  - the active port goes to UP;
  - rr_ptr = active_port+1, wrapping at PORT_CNT to 0;
  - FSM returns to IDLE.
REQ-013 All outputs SHALL be registered. port_resetl[i]=1 iff port i is UP, or the FSM is in INIT with active_port=i. port_ready[i]=1 iff port i is UP.
REQ-014 Abort on either condition below: FSM to IDLE next cycle, timer cleared, rr_ptr unchanged.
  - Active port goes ABSENT.
  - Active port receives port_reset_req; the port stays PENDING and is re-arbitrated.
REQ-015 pll_locked=0 SHALL abort any bring-up and move every UP port to PENDING. No grant is issued while pll_locked=0.
REQ-016 Simultaneous end-of-INIT and abort on the same cycle: abort wins, port not UP.
REQ-017 A per-port int_armed bit SHALL be set when port_intl[i]=1 and cleared on interrupt acceptance.
REQ-018 Interrupt candidates are ports that are UP with int_armed=1 and port_intl[i]=0. When none is pending, select the lowest-index candidate.
REQ-019 int_valid/int_port SHALL be held stable until int_valid&&int_ready; on that cycle the port is disarmed.
REQ-020 A pending interrupt whose port leaves UP SHALL be withdrawn: int_valid=0 the next cycle.
REQ-021 Timer width SHALL cover max(RESET_CYCLES, INIT_CYCLES); both parameters are >= 1.

Reset
REQ-022 rst_n=0 SHALL asynchronously set:
  - all ports ABSENT, int_armed=0;
  - FSM IDLE, rr_ptr=0, timer=0;
  - port_resetl=0, port_ready=0, busy=0, active_port=0, int_valid=0, int_port=0.
REQ-023 Deassertion SHALL be synchronised internally; first state update on the second clk edge after rst_n rises.

Verification (PORT_CNT=4, RESET_CYCLES=4, INIT_CYCLES=8)
REQ-024 Single insert:
  - Stimulus: pll_locked=1, modprsl=4'b1110 at cycle 0.
  - Response: busy=1 with active_port=0 at cycle 2; port_resetl[0] rises at cycle 6; port_ready[0] rises at cycle 14; busy=0.
REQ-025 Round-robin:
  - Stimulus: all four inserted simultaneously.
  - Response: bring-up order 0,1,2,3 with no overlap; port_resetl never has more than one bit changing per bring-up.
REQ-026 Removal mid-INIT:
  - Stimulus: port 1 modprsl=1 during INIT.
  - Response: port_resetl[1]=0 and busy=0 within 1 cycle; port 2 granted next.
REQ-027 PLL loss:
  - Stimulus: pll_locked=0 with ports 0 and 2 UP.
  - Response: port_ready=0 next cycle; no grant until pll_locked=1; both re-sequenced afterwards.
REQ-028 Interrupts:
  - Stimulus: ports 1 and 3 UP with intl low; int_ready held 0 for 5 cycles, then 1.
  - Response: int_port=1 stable throughout; after accept int_port=3; port 1 re-reports only after intl toggles high then low.
REQ-029 Async reset mid-RESET:
  - Stimulus: rst_n=0 while in RESET.
  - Response: all outputs at reset values immediately, without a clock edge.
